elev_call_sched: RTL and testbench

//  Upstream request stage for the 4-floor elevator controller. Synchronises and debounces raw

---
 rtl/elev_pkg.sv | 18 +
 rtl/elev_btn_debounce.sv | 36 +++
 rtl/elev_call_sched.sv | 137 +++++++++++++
 tb/tb_elev_call_sched.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/elev_pkg.sv
// Shared types for the elevator call scheduler: floor index, scheduler states,
// and the target-selection result.
package elev_pkg;
  localparam int NUM_FLOORS = 4;

  typedef logic [1:0] floor_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    DWELL
  } sched_state_t;

  typedef struct packed {
    logic       up;
    floor_idx_t idx;
  } pick_t;
endpackage

// File: rtl/elev_btn_debounce.sv
// One floor button: a 2-flop synchroniser, a saturating stable-high counter, and a
// single accept pulse per press. Any low sample clears the count and re-arms the pulse.
module elev_btn_debounce
  import elev_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic accept
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_FIRE = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= '0;
      accept <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      if (!sync2) cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      // Fires on the edge where the count reaches its maximum; saturation keeps it single-shot.
      accept <= sync2 && (cnt == CNT_FIRE);
    end
  end
endmodule

// File: rtl/elev_call_sched.sv
// Elevator call scheduler: debounced buttons latch pending calls, and a SCAN-ordered
// FSM presents one call at a time as a one-hot floor_btn until the car arrives.
module elev_call_sched
  import elev_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DWELL_CYCLES    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] btn_raw,
  input  logic [1:0]            car_floor,
  input  logic                  car_door,
  output logic [NUM_FLOORS-1:0] floor_btn,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up,
  output logic                  busy
);
  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_CYCLES - 1);

  logic [NUM_FLOORS-1:0] accept;
  logic [NUM_FLOORS-1:0] clr_mask;
  logic [NUM_FLOORS-1:0] drop_mask;
  sched_state_t          state;
  floor_idx_t            target;
  logic [DW-1:0]         dwell;
  logic                  arrival;
  pick_t                 pick;

  for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_btn
    elev_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .rst    (rst),
      .btn_raw(btn_raw[i]),
      .accept (accept[i])
    );
  end

  function automatic logic [NUM_FLOORS-1:0] onehot(input floor_idx_t f);
    logic [NUM_FLOORS-1:0] v;
    v    = '0;
    v[f] = 1'b1;
    return v;
  endfunction

  // SCAN: nearest call on the current side of the car, else reverse; end floors force direction.
  function automatic pick_t pick_target(input logic [NUM_FLOORS-1:0] req, input floor_idx_t car,
                                        input logic up_in);
    logic       up;
    logic       found_up;
    logic       found_dn;
    floor_idx_t idx_up;
    floor_idx_t idx_dn;
    pick_t      p;
    up = up_in;
    if (car == 2'd0) up = 1'b1;
    else if (car == 2'(NUM_FLOORS - 1)) up = 1'b0;
    found_up = 1'b0;
    found_dn = 1'b0;
    idx_up   = '0;
    idx_dn   = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (req[i] && i >= int'(car)) begin
        found_up = 1'b1;
        idx_up   = floor_idx_t'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (req[i] && i <= int'(car)) begin
        found_dn = 1'b1;
        idx_dn   = floor_idx_t'(i);
      end
    end
    if (up) begin
      p.up  = found_up;
      p.idx = found_up ? idx_up : idx_dn;
    end else begin
      p.up  = !found_dn;
      p.idx = found_dn ? idx_dn : idx_up;
    end
    return p;
  endfunction

  always_comb begin
    arrival   = (state == SERVE) && (car_floor == target) && car_door;
    clr_mask  = '0;
    drop_mask = '0;
    if (arrival) begin
      clr_mask[target]  = 1'b1;
      drop_mask[target] = 1'b1;
    end
    if (state == DWELL) drop_mask[car_floor] = 1'b1;
    pick = pick_target(pending, car_floor, dir_up);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      target    <= '0;
      dwell     <= '0;
      pending   <= '0;
      floor_btn <= '0;
      dir_up    <= 1'b1;
      busy      <= 1'b0;
    end else begin
      pending <= (pending & ~clr_mask) | (accept & ~drop_mask);
      case (state)
        IDLE: begin
          if (|pending) begin
            target    <= pick.idx;
            dir_up    <= pick.up;
            floor_btn <= onehot(pick.idx);
            busy      <= 1'b1;
            state     <= SERVE;
          end
        end
        SERVE: begin
          if (arrival) begin
            floor_btn <= '0;
            dwell     <= DWELL_LOAD;
            state     <= DWELL;
          end
        end
        DWELL: begin
          if (dwell == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            dwell <= dwell - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_elev_call_sched.sv
// Directed scenarios for elev_call_sched; expectations are queued at stimulus time and
// checked by an independent monitor, either at a scheduled cycle or on each floor_btn change.
module tb_elev_call_sched;
  localparam int F_FB = 0, F_PEND = 1, F_DIR = 2, F_BUSY = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_raw = '0;
  logic [1:0] car_floor = '0;
  logic       car_door = 1'b0;
  logic [3:0] floor_btn;
  logic [3:0] pending;
  logic       dir_up;
  logic       busy;

  typedef struct {
    int         cyc;
    int         fld;
    logic [3:0] val;
  } chk_t;

  chk_t       chk_q[$];
  logic [3:0] fb_q[$];
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;
  logic       mon_en = 1'b0;
  logic [3:0] fb_prev = '0;
  int         base;

  elev_call_sched dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .car_floor(car_floor),
    .car_door (car_door),
    .floor_btn(floor_btn),
    .pending  (pending),
    .dir_up   (dir_up),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int off, input int fld, input logic [3:0] val);
    chk_t c;
    c.cyc = base + off;
    c.fld = fld;
    c.val = val;
    chk_q.push_back(c);
  endtask

  task automatic press(input logic [3:0] m);
    btn_raw = m;
    tick(10);
    btn_raw = '0;
  endtask

  task automatic arrive(input logic [1:0] f);
    car_floor = f;
    car_door  = 1'b1;
    tick(2);
    car_door = 1'b0;
    tick(10);
  endtask

  // Monitor: scheduled status checks plus in-order check of every floor_btn change.
  initial begin
    logic [3:0] act;
    string      nm;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int i = chk_q.size() - 1; i >= 0; i--) begin
          if (chk_q[i].cyc <= cyc) begin
            case (chk_q[i].fld)
              F_FB:    begin act = floor_btn;        nm = "floor_btn"; end
              F_PEND:  begin act = pending;          nm = "pending";   end
              F_DIR:   begin act = {3'b000, dir_up}; nm = "dir_up";    end
              default: begin act = {3'b000, busy};   nm = "busy";      end
            endcase
            n_vec++;
            if (act !== chk_q[i].val) begin
              n_err++;
              $display("FAIL %s @cyc %0d: got %b want %b", nm, cyc, act, chk_q[i].val);
            end
            chk_q.delete(i);
          end
        end
        if (floor_btn !== fb_prev) begin
          n_vec++;
          if (fb_q.size() == 0) begin
            n_err++;
            $display("FAIL floor_btn_change @cyc %0d: got %b want no change", cyc, floor_btn);
          end else begin
            act = fb_q.pop_front();
            if (floor_btn !== act) begin
              n_err++;
              $display("FAIL floor_btn_change @cyc %0d: got %b want %b", cyc, floor_btn, act);
            end
          end
          fb_prev = floor_btn;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    tick(3);
    rst    = 1'b0;
    mon_en = 1'b1;

    // 1: quiet after reset
    base = cyc;
    for (int f = 0; f < 4; f++) begin
      push(1, f, (f == F_DIR) ? 4'd1 : 4'd0);
      push(100, f, (f == F_DIR) ? 4'd1 : 4'd0);
    end
    tick(101);

    // 2: bouncy press of floor 3 with car at floor 1, then arrival and dwell
    btn_raw = 4'b0100; tick(1);
    btn_raw = 4'b0000; tick(1);
    btn_raw = 4'b0100; tick(1);
    btn_raw = 4'b0000; tick(1);
    btn_raw = 4'b0100;
    base = cyc;
    push(6, F_PEND, 4'b0000);
    push(7, F_PEND, 4'b0100);
    push(7, F_FB, 4'b0000);
    push(8, F_FB, 4'b0100);
    push(8, F_BUSY, 4'd1);
    push(8, F_DIR, 4'd1);
    push(14, F_FB, 4'b0100);
    fb_q.push_back(4'b0100);
    fb_q.push_back(4'b0000);
    tick(10);
    btn_raw = '0;
    tick(5);
    car_floor = 2'd2;
    car_door  = 1'b1;
    base = cyc;
    for (int k = 1; k <= 8; k++) push(k, F_FB, 4'b0000);
    push(1, F_PEND, 4'b0000);
    push(1, F_BUSY, 4'd1);
    push(8, F_BUSY, 4'd1);
    push(9, F_BUSY, 4'd0);
    push(9, F_PEND, 4'b0000);
    push(12, F_PEND, 4'b0000);
    push(12, F_BUSY, 4'd0);
    tick(1);
    btn_raw = 4'b0100;  // re-press of the floor being dwelt at must be dropped
    tick(1);
    car_door = 1'b0;
    tick(8);
    btn_raw = '0;
    tick(5);

    // 3: car at floor 2 going up, calls at 1 and 4
    car_floor = 2'd1;
    tick(1);
    base = cyc;
    push(7, F_PEND, 4'b1001);
    push(8, F_FB, 4'b1000);
    push(8, F_DIR, 4'd1);
    fb_q.push_back(4'b1000);
    press(4'b1001);
    base = cyc;
    push(1, F_PEND, 4'b0001);
    push(1, F_FB, 4'b0000);
    push(9, F_DIR, 4'd1);
    push(10, F_FB, 4'b0001);
    push(10, F_DIR, 4'd0);
    fb_q.push_back(4'b0000);
    fb_q.push_back(4'b0001);
    arrive(2'd3);
    base = cyc;
    push(1, F_PEND, 4'b0000);
    fb_q.push_back(4'b0000);
    arrive(2'd0);

    // 4: floor 3 pressed while serving floor 4 does not retarget
    base = cyc;
    push(8, F_FB, 4'b1000);
    push(8, F_DIR, 4'd1);
    fb_q.push_back(4'b1000);
    press(4'b1000);
    base = cyc;
    push(7, F_PEND, 4'b1100);
    push(8, F_FB, 4'b1000);
    press(4'b0100);
    base = cyc;
    push(1, F_PEND, 4'b0100);
    push(10, F_FB, 4'b0100);
    push(10, F_DIR, 4'd0);
    fb_q.push_back(4'b0000);
    fb_q.push_back(4'b0100);
    arrive(2'd3);
    base = cyc;
    push(1, F_PEND, 4'b0000);
    fb_q.push_back(4'b0000);
    arrive(2'd2);

    // 5: call at the car's own floor with the door open
    car_floor = 2'd0;
    car_door  = 1'b1;
    base = cyc;
    push(7, F_PEND, 4'b0001);
    push(8, F_FB, 4'b0001);
    push(8, F_BUSY, 4'd1);
    push(8, F_DIR, 4'd1);
    push(9, F_FB, 4'b0000);
    push(9, F_PEND, 4'b0000);
    push(9, F_BUSY, 4'd1);
    push(12, F_PEND, 4'b0000);
    fb_q.push_back(4'b0001);
    fb_q.push_back(4'b0000);
    press(4'b0001);
    car_door = 1'b0;
    tick(10);

    // 6: reset in the middle of SERVE
    car_floor = 2'd3;
    tick(1);
    base = cyc;
    push(7, F_PEND, 4'b1010);
    push(8, F_FB, 4'b1000);
    push(8, F_DIR, 4'd0);
    push(12, F_PEND, 4'b1010);
    fb_q.push_back(4'b1000);
    fb_q.push_back(4'b0000);
    press(4'b1010);
    tick(2);
    rst  = 1'b1;
    base = cyc;
    push(1, F_FB, 4'b0000);
    push(1, F_PEND, 4'b0000);
    push(1, F_DIR, 4'd1);
    push(1, F_BUSY, 4'd0);
    push(8, F_PEND, 4'b0000);
    push(8, F_BUSY, 4'd0);
    tick(1);
    rst = 1'b0;
    tick(15);

    n_vec++;
    if (chk_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover_checks: got %0d want 0", chk_q.size());
    end
    n_vec++;
    if (fb_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_floor_btn_changes: got %0d want 0", fb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
